// File: rtl/pipeline_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_skid_stage
// Purpose  : Two-entry skid stage with registered outputs and tag-selective
//            squash, full flush and a saturating squash counter.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_skid_stage #(
    parameter int PAYLOAD_WIDTH  = 160,
    parameter int TAG_WIDTH      = 3,
    parameter int ZERO_ON_BUBBLE = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [(1<<TAG_WIDTH)-1:0]   squash_mask,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PAYLOAD_WIDTH-1:0]    in_data,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAYLOAD_WIDTH-1:0]    out_data,
    output logic [TAG_WIDTH-1:0]        out_tag,
    output logic [1:0]                  occupancy,
    output logic [CNT_WIDTH-1:0]        squash_count
);

    localparam int NCAND = 3;

    logic                       main_valid_q, main_valid_d;
    logic [PAYLOAD_WIDTH-1:0]   main_data_q,  main_data_d;
    logic [TAG_WIDTH-1:0]       main_tag_q,   main_tag_d;
    logic                       skid_valid_q, skid_valid_d;
    logic [PAYLOAD_WIDTH-1:0]   skid_data_q,  skid_data_d;
    logic [TAG_WIDTH-1:0]       skid_tag_q,   skid_tag_d;
    logic [CNT_WIDTH-1:0]       count_q,      count_d;

    logic                       consume;
    logic                       accept;
    logic [NCAND-1:0]           cand_valid;
    logic [PAYLOAD_WIDTH-1:0]   cand_data [NCAND];
    logic [TAG_WIDTH-1:0]       cand_tag  [NCAND];
    logic [NCAND-1:0]           killed;
    logic [NCAND-1:0]           surv;
    logic [1:0]                 kill_n;
    logic [CNT_WIDTH+1:0]       count_sum;

    // Candidates in age order: held main, skid, then the beat accepted now.
    always_comb begin
        consume       = main_valid_q & out_ready;
        accept        = in_valid & ~skid_valid_q;

        cand_valid[0] = main_valid_q & ~consume;
        cand_data[0]  = main_data_q;
        cand_tag[0]   = main_tag_q;
        cand_valid[1] = skid_valid_q;
        cand_data[1]  = skid_data_q;
        cand_tag[1]   = skid_tag_q;
        cand_valid[2] = accept;
        cand_data[2]  = in_data;
        cand_tag[2]   = in_tag;

        for (int k = 0; k < NCAND; k++) begin
            killed[k] = cand_valid[k] & ~flush &  squash_mask[cand_tag[k]];
            surv[k]   = cand_valid[k] & ~flush & ~squash_mask[cand_tag[k]];
        end
    end

    always_comb begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_data_d  = (ZERO_ON_BUBBLE != 0) ? '0 : main_data_q;
        main_tag_d   = (ZERO_ON_BUBBLE != 0) ? '0 : main_tag_q;
        skid_data_d  = (ZERO_ON_BUBBLE != 0) ? '0 : skid_data_q;
        skid_tag_d   = (ZERO_ON_BUBBLE != 0) ? '0 : skid_tag_q;

        // First survivor fills main, second fills skid.
        for (int k = 0; k < NCAND; k++) begin
            if (surv[k]) begin
                if (!main_valid_d) begin
                    main_valid_d = 1'b1;
                    main_data_d  = cand_data[k];
                    main_tag_d   = cand_tag[k];
                end else if (!skid_valid_d) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = cand_data[k];
                    skid_tag_d   = cand_tag[k];
                end
            end
        end
    end

    always_comb begin
        kill_n    = 2'(killed[0]) + 2'(killed[1]) + 2'(killed[2]);
        count_sum = (CNT_WIDTH+2)'(count_q) + (CNT_WIDTH+2)'(kill_n);
        if (count_sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) begin
            count_d = '1;
        end else begin
            count_d = count_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            count_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            count_q      <= count_d;
        end
    end

    assign in_ready     = ~skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_tag      = main_tag_q;
    assign occupancy    = 2'(main_valid_q) + 2'(skid_valid_q);
    assign squash_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_skid_stage.sv
`default_nettype none
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based model of the stage.
module tb_pipeline_skid_stage;

    localparam int PW = 160;
    localparam int TW = 3;

    logic           clk = 1'b0;
    logic           rst, flush, in_valid, out_ready;
    logic [7:0]     squash_mask;
    logic [PW-1:0]  in_data;
    logic [TW-1:0]  in_tag;

    logic           in_ready, out_valid;
    logic [PW-1:0]  out_data;
    logic [TW-1:0]  out_tag;
    logic [1:0]     occupancy;
    logic [15:0]    squash_count;

    logic           s_in_ready, s_out_valid;
    logic [PW-1:0]  s_out_data;
    logic [TW-1:0]  s_out_tag;
    logic [1:0]     s_occupancy;
    logic [1:0]     s_squash_count;

    always #5 clk = ~clk;

    pipeline_skid_stage #(
        .PAYLOAD_WIDTH(PW), .TAG_WIDTH(TW), .ZERO_ON_BUBBLE(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .squash_mask(squash_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .occupancy(occupancy), .squash_count(squash_count)
    );

    pipeline_skid_stage #(
        .PAYLOAD_WIDTH(PW), .TAG_WIDTH(TW), .ZERO_ON_BUBBLE(1), .CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .squash_mask(squash_mask),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .occupancy(s_occupancy), .squash_count(s_squash_count)
    );

    typedef struct {
        logic [PW-1:0] d;
        logic [TW-1:0] t;
    } beat_t;

    beat_t  mq[$];
    int     mcnt;
    int     errors = 0;
    int     checks = 0;
    bit     check_en = 1'b0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int            n;
        logic [PW-1:0] ed;
        logic [TW-1:0] et;
        n  = mq.size();
        ed = (n > 0) ? mq[0].d : '0;
        et = (n > 0) ? mq[0].t : '0;
        chk("out_valid",    PW'(out_valid),    PW'(n > 0));
        chk("out_data",     out_data,          ed);
        chk("out_tag",      PW'(out_tag),      PW'(et));
        chk("in_ready",     PW'(in_ready),     PW'(n < 2));
        chk("occupancy",    PW'(occupancy),    PW'(n));
        chk("squash_count", PW'(squash_count), PW'((mcnt > 65535) ? 65535 : mcnt));
        chk("sat_count",    PW'(s_squash_count), PW'((mcnt > 3) ? 3 : mcnt));
        chk("sat_out_data", s_out_data,        ed);
    endtask

    // Drive one cycle, check pre-edge outputs, advance the model past the edge.
    task automatic step(input logic iv, input logic [PW-1:0] id, input logic [TW-1:0] it,
                        input logic ordy, input logic [7:0] sm, input logic fl,
                        input logic rs, output logic acc);
        beat_t nxt[$];
        beat_t keep[$];
        beat_t b;
        in_valid    = iv;
        in_data     = id;
        in_tag      = it;
        out_ready   = ordy;
        squash_mask = sm;
        flush       = fl;
        rst         = rs;
        if (check_en) check_model();
        acc = iv && (mq.size() < 2);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            mcnt = 0;
        end else begin
            nxt = mq;
            if (nxt.size() > 0 && ordy) void'(nxt.pop_front());
            if (acc) begin
                b.d = id;
                b.t = it;
                nxt.push_back(b);
            end
            keep.delete();
            if (!fl) begin
                foreach (nxt[i]) begin
                    if (sm[nxt[i].t]) mcnt++;
                    else keep.push_back(nxt[i]);
                end
            end
            mq = keep;
        end
        #1;
    endtask

    function automatic logic [PW-1:0] rdata();
        logic [PW-1:0] d;
        for (int i = 0; i < PW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    logic          a;
    int            snap;
    logic [PW-1:0] dD;

    initial begin
        mcnt = 0;
        step(0, '0, '0, 0, 8'h00, 0, 1, a);
        check_en = 1'b1;
        chk("reset_out_valid", PW'(out_valid), '0);
        chk("reset_in_ready",  PW'(in_ready),  PW'(1));
        chk("reset_count",     PW'(squash_count), '0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            step(1, rdata(), TW'(i), 1, 8'h00, 0, 0, a);
            chk("stream_in_ready", PW'(in_ready), PW'(1));
            chk("stream_occ_le1",  PW'(occupancy <= 2'd1), PW'(1));
        end
        step(0, '0, '0, 1, 8'h00, 0, 0, a);
        step(0, '0, '0, 1, 8'h00, 0, 0, a);

        // Stall into skid, hold off C, then drain in order
        step(1, rdata(), 3'd1, 0, 8'h00, 0, 0, a);
        step(1, rdata(), 3'd2, 0, 8'h00, 0, 0, a);
        chk("stall_occ",      PW'(occupancy), PW'(2));
        chk("stall_in_ready", PW'(in_ready),  PW'(0));
        dD = rdata();
        step(1, dD, 3'd3, 0, 8'h00, 0, 0, a);
        a = 1'b0;
        for (int k = 0; k < 10 && !a; k++) step(1, dD, 3'd3, 1, 8'h00, 0, 0, a);
        chk("stall_c_accepted", PW'(a), PW'(1));
        for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 8'h00, 0, 0, a);

        // Selective squash of main (tag 2); skid (tag 5) moves up
        step(1, rdata(), 3'd2, 0, 8'h00, 0, 0, a);
        step(1, rdata(), 3'd5, 0, 8'h00, 0, 0, a);
        snap = mcnt;
        step(0, '0, '0, 0, 8'b0000_0100, 0, 0, a);
        chk("squash_tag",   PW'(out_tag),      PW'(5));
        chk("squash_occ",   PW'(occupancy),    PW'(1));
        chk("squash_count_inc", PW'(squash_count), PW'(snap + 1));
        step(0, '0, '0, 1, 8'h00, 0, 0, a);

        // Flush while accepting
        step(1, rdata(), 3'd1, 0, 8'h00, 0, 0, a);
        snap = mcnt;
        step(1, rdata(), 3'd2, 0, 8'h00, 1, 0, a);
        chk("flush_out_valid", PW'(out_valid), '0);
        chk("flush_out_data",  out_data,       '0);
        chk("flush_occ",       PW'(occupancy), '0);
        chk("flush_in_ready",  PW'(in_ready),  PW'(1));
        chk("flush_count",     PW'(squash_count), PW'(snap));

        // Reset in the middle of a stall
        step(1, rdata(), 3'd0, 0, 8'h00, 0, 0, a);
        step(1, rdata(), 3'd0, 0, 8'h00, 0, 0, a);
        chk("pre_rst_occ", PW'(occupancy), PW'(2));
        step(0, '0, '0, 0, 8'h00, 0, 1, a);
        chk("rst_out_valid", PW'(out_valid), '0);
        chk("rst_out_data",  out_data,       '0);
        chk("rst_occ",       PW'(occupancy), '0);
        chk("rst_in_ready",  PW'(in_ready),  PW'(1));
        dD = rdata();
        step(1, dD, 3'd4, 1, 8'h00, 0, 0, a);
        chk("post_rst_valid", PW'(out_valid), PW'(1));
        chk("post_rst_data",  out_data,       dD);
        step(0, '0, '0, 1, 8'h00, 0, 0, a);

        // Five squashes: narrow counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            step(1, rdata(), 3'd1, 0, 8'h00, 0, 0, a);
            step(0, '0, '0, 0, 8'b0000_0010, 0, 0, a);
        end
        chk("sat_stops_at_3", PW'(s_squash_count), PW'(3));
        chk("wide_count_5",   PW'(squash_count),   PW'(5));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rdata(), TW'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 7,
                 ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0, a);
        end
        step(0, '0, '0, 1, 8'h00, 0, 0, a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
